norm1_mul_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational `norm1` multiplier cores.
- Adds the following:
  - NUM_STAGE-deep register pipeline;
  - per-operand signed/unsigned mode;
  - ready/valid handshake with backpressure;
  - clock-enable freeze.
- Sits between the `norm1` window-sum datapath and the scaling/normalisation stage.
- Used where a 44x6 (or wider) product would otherwise close timing combinationally.

---
 rtl/norm1_mul_pkg.sv | 26 ++
 rtl/norm1_pipe_reg.sv | 24 ++
 rtl/norm1_mul_pipe.sv | 121 ++++++++++++
 tb/tb_norm1_mul_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/norm1_mul_pkg.sv
// Shared helpers for norm1_mul_pipe: full product width, dout range limits
// and the stage index type.
package norm1_mul_pkg;

  localparam int RANGE_W = 128;

  typedef int unsigned stage_idx_t;
  typedef logic signed [RANGE_W-1:0] range_t;

  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction

  function automatic range_t dout_max(input int w, input bit sgn);
    range_t one;
    one = range_t'(1);
    return sgn ? (one <<< (w - 1)) - one : (one <<< w) - one;
  endfunction

  function automatic range_t dout_min(input int w, input bit sgn);
    range_t one;
    one = range_t'(1);
    return sgn ? -(one <<< (w - 1)) : '0;
  endfunction

endpackage

// File: rtl/norm1_pipe_reg.sv
// One valid+data pipeline slot; holds its contents whenever en is low.
module norm1_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         din_valid,
  input  logic [W-1:0] din,
  output logic         dout_valid,
  output logic [W-1:0] dout
);

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_valid <= 1'b0;
      dout       <= '0;
    end else if (en) begin
      dout_valid <= din_valid;
      dout       <= din;
    end
  end

endmodule

// File: rtl/norm1_mul_pipe.sv
// Pipelined signed/unsigned multiplier with ready/valid handshake and ce freeze.
// Define NORM1_MUL_SAT_EN to clamp dout on overflow instead of wrapping.
module norm1_mul_pipe
  import norm1_mul_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int din0_WIDTH  = 44,
  parameter int din1_WIDTH  = 6,
  parameter int dout_WIDTH  = 50,
  parameter int din0_SIGNED = 0,
  parameter int din1_SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int         PW         = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int         AW         = din0_WIDTH + 1;
  localparam int         BW         = din1_WIDTH + 1;
  localparam int         RW         = dout_WIDTH + 1;
  localparam bit         ANY_SIGNED = (din0_SIGNED != 0) || (din1_SIGNED != 0);
  localparam range_t     MAXV       = dout_max(dout_WIDTH, ANY_SIGNED);
  localparam range_t     MINV       = dout_min(dout_WIDTH, ANY_SIGNED);
  localparam stage_idx_t LAST       = stage_idx_t'(NUM_STAGE - 1);

  logic          adv;
  logic [AW-1:0] a_ext;
  logic [BW-1:0] b_ext;
  logic          vld [NUM_STAGE];
  logic [RW-1:0] res [NUM_STAGE];

  // Packs {ovf, dout} from the full signed product of the widened operands.
  function automatic logic [RW-1:0] mul_res(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic signed [PW-1:0]  p;
    range_t                p_wide;
    logic                  o;
    logic [dout_WIDTH-1:0] d;
    p      = PW'($signed(a)) * PW'($signed(b));
    p_wide = range_t'(p);
    o      = (p_wide > MAXV) || (p_wide < MINV);
    d      = dout_WIDTH'(p_wide);
`ifdef NORM1_MUL_SAT_EN
    if (o) d = (p_wide > MAXV) ? dout_WIDTH'(MAXV) : dout_WIDTH'(MINV);
`endif
    return {o, d};
  endfunction

  assign a_ext    = (din0_SIGNED != 0) ? {din0[din0_WIDTH-1], din0} : {1'b0, din0};
  assign b_ext    = (din1_SIGNED != 0) ? {din1[din1_WIDTH-1], din1} : {1'b0, din1};

  assign adv       = ce && !reset && (!vld[LAST] || out_ready);
  assign in_ready  = adv;
  assign out_valid = vld[LAST];
  assign dout      = res[LAST][dout_WIDTH-1:0];
  assign ovf       = res[LAST][dout_WIDTH];

  generate
    if (NUM_STAGE == 1) begin : g_single
      logic          vld_reg;
      logic [RW-1:0] res_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_reg <= 1'b0;
          res_reg <= '0;
        end else if (adv) begin
          vld_reg <= in_valid;
          res_reg <= mul_res(a_ext, b_ext);
        end
      end

      assign vld[0] = vld_reg;
      assign res[0] = res_reg;
    end else begin : g_multi
      logic          vld_reg;
      logic [AW-1:0] a_reg;
      logic [BW-1:0] b_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_reg <= 1'b0;
          a_reg   <= '0;
          b_reg   <= '0;
        end else if (adv) begin
          vld_reg <= in_valid;
          a_reg   <= a_ext;
          b_reg   <= b_ext;
        end
      end

      // Multiply sits between stage 0 and stage 1; later stages only delay it.
      assign vld[0] = vld_reg;
      assign res[0] = mul_res(a_reg, b_reg);

      for (genvar gi = 1; gi < NUM_STAGE; gi++) begin : g_stage
        norm1_pipe_reg #(
          .W(RW)
        ) u_stage (
          .clk       (clk),
          .reset     (reset),
          .en        (adv),
          .din_valid (vld[gi-1]),
          .din       (res[gi-1]),
          .dout_valid(vld[gi]),
          .dout      (res[gi])
        );
      end
    end
  endgenerate

endmodule

// File: tb/tb_norm1_mul_pipe.sv
// Scoreboard bench for norm1_mul_pipe: unsigned 44x6->50 and mixed-sign 8x8->8 instances
// share one handshake; a negedge monitor checks every output against a queued model result.
module tb_norm1_mul_pipe;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset, ce, in_valid, out_ready;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
  logic [43:0] a0;
  logic [5:0]  b0;
  logic [49:0] dout0;
  logic [7:0]  a1, b1, dout1;

  always #5 clk = ~clk;

  norm1_mul_pipe #(
    .ID(1), .NUM_STAGE(N), .din0_WIDTH(44), .din1_WIDTH(6), .dout_WIDTH(50),
    .din0_SIGNED(0), .din1_SIGNED(0)
  ) dut0 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready0),
    .din0(a0), .din1(b0), .out_valid(out_valid0), .out_ready(out_ready),
    .dout(dout0), .ovf(ovf0)
  );

  norm1_mul_pipe #(
    .ID(2), .NUM_STAGE(N), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
    .din0_SIGNED(1), .din1_SIGNED(0)
  ) dut1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready1),
    .din0(a1), .din1(b1), .out_valid(out_valid1), .out_ready(out_ready),
    .dout(dout1), .ovf(ovf1)
  );

  typedef struct {
    logic [49:0] d0;
    logic        o0;
    logic [7:0]  d1;
    logic        o1;
    int          cyc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   exp_lat = 0;

  logic [43:0] da0 [6] = '{44'hFFFFFFFFFFF, 44'h0, 44'h1, 44'h123456789AB, 44'hFFFFFFFFFFF, 44'h80000000000};
  logic [5:0]  db0 [6] = '{6'd63, 6'd63, 6'd0, 6'd37, 6'd1, 6'd32};
  logic [7:0]  da1 [6] = '{8'hFF, 8'd20, 8'h80, 8'h80, 8'd127, 8'd64};
  logic [7:0]  db1 [6] = '{8'd5, 8'd20, 8'd1, 8'd2, 8'd1, 8'd2};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Operand value per its signedness, as a plain integer.
  function automatic logic signed [127:0] sval(input logic [127:0] raw, input int w, input bit sgn);
    logic signed [127:0] one, v;
    one = 1;
    v = $signed(raw & ((one << w) - 1));
    if (sgn && raw[w-1]) v = v - (one << w);
    return v;
  endfunction

  function automatic void model(input logic [127:0] a, input int aw, input bit as,
                                input logic [127:0] b, input int bw, input bit bs,
                                input int dw, output logic [63:0] d, output logic o);
    logic signed [127:0] one, p, mx, mn, r;
    one = 1;
    p  = sval(a, aw, as) * sval(b, bw, bs);
    mx = (as || bs) ? (one << (dw - 1)) - 1 : (one << dw) - 1;
    mn = (as || bs) ? -(one << (dw - 1)) : 0;
    o  = (p > mx) || (p < mn);
    r  = p;
`ifdef NORM1_MUL_SAT_EN
    if (p > mx) r = mx;
    else if (p < mn) r = mn;
`endif
    d = 64'(r & ((one << dw) - 1));
  endfunction

  logic [63:0] md;
  logic        mo;
  exp_t        ent;

  // Monitor and scoreboard: mid-cycle, records accepted inputs and checks presented outputs.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
    end else begin
      chk("in_ready_rule", 64'(in_ready0), 64'(ce && (!out_valid0 || out_ready)));
      chk("valid_align", 64'(out_valid1), 64'(out_valid0));
      if (out_valid0) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: dout0=%0h dout1=%0h with no pending item (cycle %0d)", dout0, dout1, cyc);
        end else begin
          chk("dout0", 64'(dout0), 64'(q[0].d0));
          chk("ovf0", 64'(ovf0), 64'(q[0].o0));
          chk("dout1", 64'(dout1), 64'(q[0].d1));
          chk("ovf1", 64'(ovf1), 64'(q[0].o1));
          if (ce && out_ready) begin
            if (q[0].lat != 0) chk("latency", 64'(cyc - q[0].cyc), 64'(q[0].lat));
            $display("out: dout0=%0h ovf0=%0b dout1=%0h ovf1=%0b", dout0, ovf0, dout1, ovf1);
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready0) begin
        model(128'(a0), 44, 1'b0, 128'(b0), 6, 1'b0, 50, md, mo);
        ent.d0 = md[49:0];
        ent.o0 = mo;
        model(128'(a1), 8, 1'b1, 128'(b1), 8, 1'b0, 8, md, mo);
        ent.d1 = md[7:0];
        ent.o1 = mo;
        ent.cyc = cyc;
        ent.lat = exp_lat;
        q.push_back(ent);
        $display("in: din0=%0h din1=%0h | din0=%0h din1=%0h", a0, b0, a1, b1);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   sent;
    int   k;
    logic acc;

    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) cycle();
    chk("rst_out_valid", 64'(out_valid0), 64'd0);
    chk("rst_in_ready", 64'(in_ready0), 64'd0);
    chk("rst_dout", 64'(dout0), 64'd0);
    chk("rst_ovf", 64'(ovf1), 64'd0);
    reset = 1'b0;

    // Directed operands, back-to-back with continuous ready.
    exp_lat = N;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      a0 = da0[i]; b0 = db0[i]; a1 = da1[i]; b1 = db1[i];
      cycle();
    end
    in_valid = 1'b0;
    exp_lat = 0;
    repeat (N + 2) cycle();

    // Backpressure: six items, out_ready low for four cycles mid-stream.
    sent = 0;
    k = 0;
    while (sent < 6 && k < 60) begin
      in_valid = 1'b1;
      a0 = 44'(sent); b0 = 6'(sent + 1);
      a1 = 8'($urandom); b1 = 8'($urandom);
      out_ready = !(k >= 3 && k < 7);
      #1;
      acc = in_ready0;
      if (k >= 3 && k < 7) chk("bp_in_ready", 64'(in_ready0), 64'd0);
      cycle();
      if (acc) sent++;
      k++;
    end
    chk("bp_all_sent", 64'(sent), 64'd6);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (N + 2) cycle();

    // ce dropped for two cycles with one item in flight.
    in_valid = 1'b1;
    a0 = 44'({$urandom, $urandom}); b0 = 6'($urandom);
    a1 = 8'($urandom); b1 = 8'($urandom);
    exp_lat = N + 2;
    cycle();
    in_valid = 1'b0;
    exp_lat = 0;
    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("ce_in_ready", 64'(in_ready0), 64'd0);
      cycle();
    end
    ce = 1'b1;
    repeat (N + 2) cycle();

    // Reset with two items in flight; they must never appear.
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a0 = 44'($urandom); b0 = 6'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("flush_out_valid", 64'(out_valid0), 64'd0);
    chk("flush_dout", 64'(dout0), 64'd0);
    chk("flush_ovf", 64'(ovf0), 64'd0);
    chk("flush_dout1", 64'(dout1), 64'd0);
    in_valid = 1'b1;
    a0 = 44'd7; b0 = 6'd9; a1 = 8'hF0; b1 = 8'd3;
    exp_lat = N;
    cycle();
    in_valid = 1'b0;
    exp_lat = 0;
    repeat (N + 2) cycle();

    // Random traffic with random backpressure and ce.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ce        = ($urandom_range(0, 7) != 0);
      a0 = 44'({$urandom, $urandom}); b0 = 6'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom);
      cycle();
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    ce = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
